// File: rtl/ppu_pkg.sv
// Shared types and address map for the PPU video-memory port and OAM DMA.
package ppu_pkg;

  typedef enum logic [1:0] {
    PPU_H_BLANK = 2'd0,
    PPU_V_BLANK = 2'd1,
    PPU_SCAN    = 2'd2,
    PPU_DRAW    = 2'd3
  } PPU_STATES_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_READ,
    DMA_WRITE
  } DMA_STATES_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_PPU,
    OWNER_CPU
  } OWNER_t;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END  = 16'h9FFF;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_END   = 16'hFE9F;
  localparam logic [15:0] DMA_REG   = 16'hFF46;

  // Echo-RAM pages E0-FF alias work RAM at C0-DF.
  function automatic logic [7:0] dma_src_fold(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA sequencer: copies DMA_LEN bytes from {src_hi, idx} into OAM, one read/write pair per byte.
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int unsigned DMA_LEN         = 160,
  parameter int unsigned DMA_START_DELAY = 1,
  parameter logic [15:0] DST_BASE        = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_trig,
  input  logic [7:0]  i_trig_data,
  input  logic        i_grant,
  input  logic [7:0]  i_src_data,
  output logic        o_req,
  output logic [15:0] o_dst_addr,
  output logic [7:0]  o_wdata,
  output logic [15:0] o_src_addr,
  output logic        o_src_rd,
  output logic        o_active
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(DMA_START_DELAY - 1);

  DMA_STATES_t r_state;
  logic [7:0]  r_idx;
  logic [7:0]  r_src_hi;
  logic [7:0]  r_data;
  logic [7:0]  r_dly;
  logic        r_first;
  logic        r_active;

  // Source data is only valid in the first WRITE cycle; later (stalled) cycles use the latched copy.
  logic [7:0] w_byte;
  assign w_byte = r_first ? i_src_data : r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DMA_IDLE;
      r_idx    <= '0;
      r_src_hi <= '0;
      r_data   <= '0;
      r_dly    <= '0;
      r_first  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      if (r_first) begin
        r_data  <= i_src_data;
        r_first <= 1'b0;
      end
      if (i_trig) begin
        r_src_hi <= dma_src_fold(i_trig_data);
        r_idx    <= '0;
        r_dly    <= '0;
        r_active <= 1'b1;
        r_state  <= DMA_START;
      end else begin
        case (r_state)
          DMA_IDLE: ;
          DMA_START: begin
            if (r_dly == DLY_LAST) r_state <= DMA_READ;
            else                   r_dly   <= r_dly + 8'd1;
          end
          DMA_READ: begin
            r_state <= DMA_WRITE;
            r_first <= 1'b1;
          end
          DMA_WRITE: begin
            if (i_grant) begin
              if (r_idx == LAST_IDX) begin
                r_state  <= DMA_IDLE;
                r_active <= 1'b0;
              end else begin
                r_idx   <= r_idx + 8'd1;
                r_state <= DMA_READ;
              end
            end
          end
          default: r_state <= DMA_IDLE;
        endcase
      end
    end
  end

  assign o_req      = (r_state == DMA_WRITE);
  assign o_dst_addr = DST_BASE + {8'h00, r_idx};
  assign o_wdata    = w_byte;
  assign o_src_addr = {r_src_hi, r_idx};
  assign o_src_rd   = (r_state == DMA_READ);
  assign o_active   = r_active;

endmodule

// File: rtl/ppu_mem_arbiter.sv
// Video-memory port arbiter: PPU > OAM DMA > CPU, with PPU-mode CPU locks and read-return steering.
module ppu_mem_arbiter
  import ppu_pkg::*;
#(
  parameter int unsigned DMA_LEN         = 160,
  parameter int unsigned DMA_START_DELAY = 1,
  parameter logic [15:0] OAM_BASE        = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        RD,
  input  logic        WR,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  output logic        CPU_SEL,
  input  logic [1:0]  PPU_MODE,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA_in,
  output logic [15:0] VMEM_ADDR,
  output logic        VMEM_RD,
  output logic        VMEM_WR,
  output logic [7:0]  VMEM_WDATA,
  input  logic [7:0]  VMEM_RDATA,
  output logic [15:0] DMA_SRC_ADDR,
  output logic        DMA_SRC_RD,
  input  logic [7:0]  DMA_SRC_DATA,
  output logic        DMA_ACTIVE
);

  PPU_STATES_t w_mode;
  logic        w_vram_hit, w_oam_hit, w_hit;
  logic        w_vram_lock, w_oam_lock, w_cpu_ok;
  logic        w_ppu_gnt, w_dma_req, w_dma_gnt, w_cpu_gnt, w_trig;
  logic [15:0] w_dma_addr;
  logic [7:0]  w_dma_wdata, w_mmio;

  OWNER_t      r_owner;
  logic        r_cpu_sel, r_cpu_drop;
  logic [7:0]  r_mmio;

  assign w_mode      = PPU_STATES_t'(PPU_MODE);
  assign w_vram_hit  = (ADDR >= VRAM_BASE) && (ADDR <= VRAM_END);
  assign w_oam_hit   = (ADDR >= ppu_pkg::OAM_BASE) && (ADDR <= OAM_END);
  assign w_hit       = w_vram_hit || w_oam_hit;
  assign w_vram_lock = (w_mode == PPU_DRAW) || DMA_ACTIVE;
  assign w_oam_lock  = (w_mode == PPU_SCAN) || (w_mode == PPU_DRAW) || DMA_ACTIVE;
  assign w_cpu_ok    = (w_vram_hit && !w_vram_lock) || (w_oam_hit && !w_oam_lock);
  assign w_trig      = WR && (ADDR == DMA_REG);

  assign w_ppu_gnt = !rst && PPU_RD && ((w_mode == PPU_SCAN) || (w_mode == PPU_DRAW));
  assign w_dma_gnt = !rst && w_dma_req && !w_ppu_gnt;
  assign w_cpu_gnt = !rst && (RD || WR) && w_cpu_ok && !w_ppu_gnt && !w_dma_gnt;

  ppu_oam_dma #(
    .DMA_LEN         (DMA_LEN),
    .DMA_START_DELAY (DMA_START_DELAY),
    .DST_BASE        (OAM_BASE)
  ) u_dma (
    .clk         (clk),
    .rst         (rst),
    .i_trig      (w_trig),
    .i_trig_data (MMIO_DATA_out),
    .i_grant     (w_dma_gnt),
    .i_src_data  (DMA_SRC_DATA),
    .o_req       (w_dma_req),
    .o_dst_addr  (w_dma_addr),
    .o_wdata     (w_dma_wdata),
    .o_src_addr  (DMA_SRC_ADDR),
    .o_src_rd    (DMA_SRC_RD),
    .o_active    (DMA_ACTIVE)
  );

  always_comb begin
    VMEM_ADDR  = '0;
    VMEM_RD    = 1'b0;
    VMEM_WR    = 1'b0;
    VMEM_WDATA = '0;
    if (w_ppu_gnt) begin
      VMEM_ADDR = PPU_ADDR;
      VMEM_RD   = 1'b1;
    end else if (w_dma_gnt) begin
      VMEM_ADDR  = w_dma_addr;
      VMEM_WR    = 1'b1;
      VMEM_WDATA = w_dma_wdata;
    end else if (w_cpu_gnt) begin
      VMEM_ADDR  = ADDR;
      VMEM_RD    = RD;
      VMEM_WR    = WR;
      VMEM_WDATA = MMIO_DATA_out;
    end
  end

  // CPU read data persists in r_mmio until the next CPU read; a dropped read forces FF.
  assign w_mmio = (r_owner == OWNER_CPU) ? VMEM_RDATA :
                  r_cpu_drop             ? 8'hFF      : r_mmio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWNER_NONE;
      r_cpu_sel  <= 1'b0;
      r_cpu_drop <= 1'b0;
      r_mmio     <= '1;
    end else begin
      r_owner    <= w_ppu_gnt             ? OWNER_PPU :
                    (w_cpu_gnt && RD)     ? OWNER_CPU : OWNER_NONE;
      r_cpu_sel  <= (RD || WR) && w_hit;
      r_cpu_drop <= RD && w_hit && !w_cpu_gnt;
      r_mmio     <= w_mmio;
    end
  end

  assign MMIO_DATA_in = w_mmio;
  assign PPU_DATA_in  = (r_owner == OWNER_PPU) ? VMEM_RDATA : 8'hFF;
  assign CPU_SEL      = r_cpu_sel;

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Directed bench for ppu_mem_arbiter with a behavioural VRAM/OAM and DMA source.
module tb_ppu_mem_arbiter;

  localparam logic [1:0] HB = 2'd0, SCAN = 2'd2, DRAW = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ADDR;
  logic        RD, WR;
  logic [7:0]  MMIO_DATA_out, MMIO_DATA_in;
  logic        CPU_SEL;
  logic [1:0]  PPU_MODE;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA_in;
  logic [15:0] VMEM_ADDR;
  logic        VMEM_RD, VMEM_WR;
  logic [7:0]  VMEM_WDATA;
  logic [7:0]  VMEM_RDATA = 8'h00;
  logic [15:0] DMA_SRC_ADDR;
  logic        DMA_SRC_RD;
  logic [7:0]  DMA_SRC_DATA = 8'h00;
  logic        DMA_ACTIVE;

  logic [7:0]  mem [0:65535];
  int          n_tests = 0;
  int          n_fail  = 0;

  ppu_mem_arbiter #(
    .DMA_LEN         (160),
    .DMA_START_DELAY (1),
    .OAM_BASE        (16'hFE00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ADDR          (ADDR),
    .RD            (RD),
    .WR            (WR),
    .MMIO_DATA_out (MMIO_DATA_out),
    .MMIO_DATA_in  (MMIO_DATA_in),
    .CPU_SEL       (CPU_SEL),
    .PPU_MODE      (PPU_MODE),
    .PPU_RD        (PPU_RD),
    .PPU_ADDR      (PPU_ADDR),
    .PPU_DATA_in   (PPU_DATA_in),
    .VMEM_ADDR     (VMEM_ADDR),
    .VMEM_RD       (VMEM_RD),
    .VMEM_WR       (VMEM_WR),
    .VMEM_WDATA    (VMEM_WDATA),
    .VMEM_RDATA    (VMEM_RDATA),
    .DMA_SRC_ADDR  (DMA_SRC_ADDR),
    .DMA_SRC_RD    (DMA_SRC_RD),
    .DMA_SRC_DATA  (DMA_SRC_DATA),
    .DMA_ACTIVE    (DMA_ACTIVE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (VMEM_WR) mem[VMEM_ADDR] <= VMEM_WDATA;
    if (VMEM_RD) VMEM_RDATA <= mem[VMEM_ADDR];
    if (DMA_SRC_RD) DMA_SRC_DATA <= DMA_SRC_ADDR[7:0] ^ 8'h5A;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    RD = rd; WR = wr; ADDR = a; MMIO_DATA_out = d;
  endtask

  task automatic trigger(input logic [7:0] v);
    cpu(1'b0, 1'b1, 16'hFF46, v);
    @(negedge clk);
    tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic oam_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
    check(tag, bad, 0);
  endtask

  // Runs cycles after a trigger, checking every source read and OAM write on the way.
  task automatic dma_watch(input logic [7:0] hi0, input int stall_idx, input int restart_idx,
                           input logic [7:0] restart_val, input int rst_idx,
                           output int act, output int nwr);
    logic [7:0] hi;
    int widx, stall_left;
    bit seen, done, do_restart, do_rst, rst_now, stalling, post_stall;
    bit stall_used, restart_used, rst_used;
    hi = hi0; widx = 0; act = 0; nwr = 0; stall_left = 0;
    seen = 0; done = 0; do_restart = 0; do_rst = 0; post_stall = 0;
    stall_used = 0; restart_used = 0; rst_used = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      stalling = (stall_left > 0);
      PPU_MODE = stalling ? SCAN : HB;
      PPU_RD   = stalling;
      PPU_ADDR = 16'h8000;
      if (do_restart) cpu(1'b0, 1'b1, 16'hFF46, restart_val);
      else            cpu(1'b0, 1'b0, 16'h0000, 8'h00);
      rst_now = do_rst;
      rst     = rst_now;
      @(negedge clk);
      if (DMA_ACTIVE) begin act++; seen = 1; end
      if (stalling) begin
        check("stall_ppu_rd", VMEM_RD, 1);
        check("stall_ppu_addr", VMEM_ADDR, 16'h8000);
        check("stall_no_wr", VMEM_WR, 0);
        if (stall_left < 5) check("stall_ppu_data", PPU_DATA_in, 8'hA5);
        stall_left--;
        if (stall_left == 0) post_stall = 1;
      end else if (post_stall) begin
        check("deferred_wr", VMEM_WR, 1);
        post_stall = 0;
      end
      if (rst_now) check("rst_no_wr", VMEM_WR, 0);
      if (VMEM_WR) begin
        check("oam_addr", VMEM_ADDR, 16'hFE00 + 16'(widx));
        check("oam_data", VMEM_WDATA, 8'(widx) ^ 8'h5A);
        widx++; nwr++;
      end
      if (do_restart) begin hi = restart_val; widx = 0; do_restart = 0; end
      if (DMA_SRC_RD) begin
        check("src_addr", DMA_SRC_ADDR, {hi, 8'(widx)});
        if (widx == stall_idx && !stall_used) begin stall_left = 5; stall_used = 1; end
        if (widx == restart_idx && !restart_used) begin do_restart = 1; restart_used = 1; end
        if (widx == rst_idx && !rst_used) begin do_rst = 1; rst_used = 1; end
      end
      tick();
      if (rst_now) begin rst = 1'b0; do_rst = 0; done = 1; end
      else if (seen && !DMA_ACTIVE) done = 1;
    end
    PPU_MODE = HB; PPU_RD = 1'b0;
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    if (!done) check("dma_timeout", 0, 1);
  endtask

  initial begin
    int act, nwr;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    mem[16'h9800] <= 8'h77;
    rst = 1'b1; PPU_MODE = HB; PPU_RD = 1'b0; PPU_ADDR = 16'h0000;
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    tick(); tick();

    @(negedge clk);
    check("rst_vmem_wr", VMEM_WR, 0);
    check("rst_vmem_rd", VMEM_RD, 0);
    check("rst_vmem_addr", VMEM_ADDR, 0);
    check("rst_mmio", MMIO_DATA_in, 8'hFF);
    check("rst_ppu_data", PPU_DATA_in, 8'hFF);
    check("rst_dma_active", DMA_ACTIVE, 0);
    check("rst_src_rd", DMA_SRC_RD, 0);
    check("rst_src_addr", DMA_SRC_ADDR, 0);
    check("rst_cpu_sel", CPU_SEL, 0);
    rst = 1'b0;
    tick();

    // CPU access in H-blank
    cpu(1'b0, 1'b1, 16'h8000, 8'hA5);
    @(negedge clk);
    check("hb_wr_strobe", VMEM_WR, 1);
    check("hb_wr_addr", VMEM_ADDR, 16'h8000);
    check("hb_wr_data", VMEM_WDATA, 8'hA5);
    tick();
    cpu(1'b1, 1'b0, 16'h8000, 8'h00);
    @(negedge clk);
    check("hb_rd_strobe", VMEM_RD, 1);
    check("hb_cpu_sel_after_wr", CPU_SEL, 1);
    tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    check("hb_rd_data", MMIO_DATA_in, 8'hA5);
    check("hb_cpu_sel_after_rd", CPU_SEL, 1);
    tick();
    @(negedge clk);
    check("hb_rd_hold", MMIO_DATA_in, 8'hA5);
    check("cpu_sel_idle", CPU_SEL, 0);
    tick();

    // VRAM locked in DRAW
    PPU_MODE = DRAW;
    cpu(1'b0, 1'b1, 16'h9800, 8'h11);
    @(negedge clk); check("draw_wr_blocked", VMEM_WR, 0); tick();
    cpu(1'b1, 1'b0, 16'h9800, 8'h00);
    @(negedge clk); check("draw_rd_blocked", VMEM_RD, 0); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk); check("draw_rd_ff", MMIO_DATA_in, 8'hFF); tick();
    PPU_MODE = HB;
    cpu(1'b1, 1'b0, 16'h9800, 8'h00); @(negedge clk); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk); check("draw_wr_dropped", MMIO_DATA_in, 8'h77); tick();

    // OAM locked in SCAN
    PPU_MODE = SCAN;
    cpu(1'b0, 1'b1, 16'hFE00, 8'h22);
    @(negedge clk); check("scan_wr_blocked", VMEM_WR, 0); tick();
    cpu(1'b1, 1'b0, 16'hFE00, 8'h00);
    @(negedge clk); check("scan_rd_blocked", VMEM_RD, 0); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk); check("scan_rd_ff", MMIO_DATA_in, 8'hFF); tick();
    PPU_MODE = HB;
    cpu(1'b1, 1'b0, 16'hFE00, 8'h00); @(negedge clk); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk); check("scan_wr_dropped", MMIO_DATA_in, 8'h00); tick();

    // PPU reads: ignored in H-blank, win over CPU in SCAN
    PPU_RD = 1'b1; PPU_ADDR = 16'h8000;
    @(negedge clk); check("ppu_hb_no_rd", VMEM_RD, 0); tick();
    PPU_RD = 1'b0;
    @(negedge clk); check("ppu_hb_data_ff", PPU_DATA_in, 8'hFF); tick();
    PPU_MODE = SCAN; PPU_RD = 1'b1;
    cpu(1'b1, 1'b0, 16'h9800, 8'h00);
    @(negedge clk); check("ppu_scan_addr", VMEM_ADDR, 16'h8000); tick();
    PPU_RD = 1'b0; PPU_MODE = HB;
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    check("ppu_scan_data", PPU_DATA_in, 8'hA5);
    check("cpu_lost_priority_ff", MMIO_DATA_in, 8'hFF);
    tick();

    // Plain DMA from C1
    trigger(8'hC1);
    dma_watch(8'hC1, -1, -1, 8'h00, -1, act, nwr);
    check("dma_active_cycles", act, 321);
    check("dma_writes", nwr, 160);
    oam_compare("dma_oam_contents");

    // DMA stalled by 5 PPU reads during WRITE of idx 10
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] <= 8'h00;
    tick();
    trigger(8'hC1);
    dma_watch(8'hC1, 10, -1, 8'h00, -1, act, nwr);
    check("stall_active_cycles", act, 326);
    check("stall_writes", nwr, 160);
    oam_compare("stall_oam_contents");

    // Echo fold E2->C2, restart with C3 at idx 50
    trigger(8'hE2);
    dma_watch(8'hC2, -1, 50, 8'hC3, -1, act, nwr);
    check("restart_active_cycles", act, 424);
    check("restart_writes", nwr, 211);

    // Reset in the middle of a transfer
    trigger(8'hC1);
    dma_watch(8'hC1, -1, -1, 8'h00, 80, act, nwr);
    @(negedge clk);
    check("midrst_active", DMA_ACTIVE, 0);
    check("midrst_no_wr", VMEM_WR, 0);
    check("midrst_mmio", MMIO_DATA_in, 8'hFF);
    tick();
    check("midrst_writes", nwr, 80);
    trigger(8'hC1);
    dma_watch(8'hC1, -1, -1, 8'h00, -1, act, nwr);
    check("post_rst_active_cycles", act, 321);
    check("post_rst_writes", nwr, 160);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
